// File: rtl/dbus_ctrl_pkg.sv
// Shared types and constants for the data-side bus controller.
package dbus_ctrl_pkg;

  localparam int unsigned StallBus       = 6;
  localparam int unsigned RegBus         = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam int unsigned DbusTimeoutDef = 255;

  typedef enum logic [1:0] {
    DbusIdle = 2'b00,
    DbusBusy = 2'b01,
    DbusWait = 2'b10
  } dbus_state_e;

endpackage

// File: rtl/dbus_ctrl.sv
// Data-side Wishbone-classic master for the MIPS MEM stage.
// Optional bus watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DbusTimeoutDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic                flush,
  input  logic                cpu_ce,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [3:0]          cpu_sel,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stall_req,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [3:0]          wb_sel_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  output logic                bus_err
);

  dbus_state_e       state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              timeout_hit;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Fires in the BUSY cycle whose increment would bring the count to TIMEOUT.
  assign timeout_hit = (state_q == DbusBusy) && !wb_ack_i && !flush && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DbusIdle && cpu_ce && !flush) begin
      cnt_d = '0;
    end else if (state_q == DbusBusy && !wb_ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DbusIdle;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // Next state and next bus register values.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    rd_buf_d = rd_buf_q;
    case (state_q)
      DbusIdle: begin
        if (cpu_ce && !flush) begin
          state_d = DbusBusy;
          cyc_d   = 1'b1;
          we_d    = cpu_we;
          adr_d   = cpu_addr;
          sel_d   = cpu_sel;
          dat_d   = cpu_data_i;
        end
      end
      DbusBusy: begin
        if (flush) begin
          state_d = DbusIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          rd_buf_d = wb_dat_i;
          state_d  = (|stall) ? DbusWait : DbusIdle;
        end else if (timeout_hit) begin
          state_d = DbusIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      DbusWait: begin
        if (flush || !(|stall)) begin
          state_d = DbusIdle;
        end
      end
      default: begin
        state_d = DbusIdle;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Combinational handshake back to the pipeline.
  always_comb begin
    stall_req  = 1'b0;
    cpu_data_o = '0;
    case (state_q)
      DbusIdle: begin
        stall_req = cpu_ce & ~flush;
      end
      DbusBusy: begin
        if (flush) begin
          stall_req = 1'b0;
        end else if (wb_ack_i) begin
          cpu_data_o = wb_dat_i;
        end else if (timeout_hit) begin
          cpu_data_o = '1;
        end else begin
          stall_req = 1'b1;
        end
      end
      DbusWait: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stall_req = 1'b0;
      end
    endcase
  end

  assign bus_err  = timeout_hit;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl; adds a watchdog case when DBUS_TIMEOUT_EN is defined.
module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stall_req;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        bus_err;

  always #5 clk = ~clk;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 255;
`endif

  dbus_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TbTimeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cpu_ce    (cpu_ce),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_sel   (cpu_sel),
    .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o),
    .stall_req (stall_req),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .bus_err   (bus_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access: request cycle, `waits` slave wait states, ack, then optional WAIT_STALL hold.
  task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] rdata, input int waits,
                        input logic [5:0] ack_stall, input int hold);
    req_t r;
    next_cycle();
    cpu_ce = 1'b1; cpu_we = we; cpu_addr = adr; cpu_sel = sel; cpu_data_i = dat;
    stall = 6'b001111;
    req_q.push_back({we, adr, sel, dat});
    rd_q.push_back(rdata);
    @(negedge clk);
    check("req_stall", stall_req, 1);
    for (int i = 0; i <= waits; i++) begin
      next_cycle();
      if (i == waits) begin
        wb_ack_i = 1'b1; wb_dat_i = rdata; stall = ack_stall;
      end else begin
        wb_ack_i = 1'b0; wb_dat_i = $urandom; stall = 6'b001111;
      end
      @(negedge clk);
      if (i == 0) r = req_q.pop_front();
      check("cyc", wb_cyc_o, 1);
      check("stb", wb_stb_o, 1);
      check("we", wb_we_o, r.we);
      check("adr", wb_adr_o, r.adr);
      check("sel", wb_sel_o, r.sel);
      check("dat", wb_dat_o, r.dat);
      check("busy_stall", stall_req, (i < waits));
      check("bus_err", bus_err, 0);
      if (i == waits) check("rdata", cpu_data_o, rd_q.pop_front());
    end
    next_cycle();
    wb_ack_i = 1'b0;
    if (ack_stall != 6'd0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("wait_data", cpu_data_o, rdata);
        check("wait_stb", wb_stb_o, 0);
        check("wait_stall_req", stall_req, 0);
        check("wait_state", dut.state_q, DbusWait);
        next_cycle();
      end
      stall = 6'd0;
      @(negedge clk);
      check("wait_last", cpu_data_o, rdata);
      check("wait_last_stb", wb_stb_o, 0);
      next_cycle();
    end
    cpu_ce = 1'b0;
    stall  = 6'd0;
    @(negedge clk);
    check("idle_cyc", wb_cyc_o, 0);
    check("idle_data", cpu_data_o, 0);
    check("idle_state", dut.state_q, DbusIdle);
    check("idle_stall", stall_req, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_sel = '0; cpu_data_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_data", cpu_data_o, 0);
    check("rst_buf", dut.rd_buf_q, 0);
    rst = 1'b1;

    // Zero-wait load, 3-wait store, ack while another stage stalls.
    access(1'b0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 6'd0, 0);
    access(1'b1, 32'h204, 4'b0011, 32'h0000_1234, 32'h0BAD_F00D, 3, 6'd0, 0);
    access(1'b0, 32'h300, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 6'b000011, 5);
    for (int k = 0; k < 4; k++) begin
      access(1'($urandom), {$urandom_range(0, 255), 2'b00}, 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 3)), 6'd0, 0);
    end

    // Flush on the second wait cycle; the late ack must be ignored.
    next_cycle();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400; cpu_sel = 4'hF; stall = 6'b001111;
    @(negedge clk);
    check("fl_req", stall_req, 1);
    next_cycle();
    @(negedge clk);
    check("fl_busy1", stall_req, 1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("fl_stall", stall_req, 0);
    check("fl_data", cpu_data_o, 0);
    next_cycle();
    flush = 1'b0; cpu_ce = 1'b0; stall = '0; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk);
    check("fl_cyc", wb_cyc_o, 0);
    check("fl_stb", wb_stb_o, 0);
    check("fl_late_data", cpu_data_o, 0);
    check("fl_late_stall", stall_req, 0);
    check("fl_state", dut.state_q, DbusIdle);
    next_cycle();
    wb_ack_i = 1'b0;
    cpu_ce = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("fl_idle_stall", stall_req, 0);
    next_cycle();
    cpu_ce = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fl_idle_cyc", wb_cyc_o, 0);

    // Asynchronous reset while BUSY.
    next_cycle();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500; cpu_sel = 4'hC; cpu_data_i = 32'h77;
    stall = 6'b001111;
    next_cycle();
    #2;
    check("pre_rst_cyc", wb_cyc_o, 1);
    rst = 1'b0; cpu_ce = 1'b0; stall = '0;
    #1;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_stb", wb_stb_o, 0);
    check("arst_we", wb_we_o, 0);
    check("arst_adr", wb_adr_o, 0);
    check("arst_sel", wb_sel_o, 0);
    check("arst_dat", wb_dat_o, 0);
    check("arst_stall", stall_req, 0);
    check("arst_data", cpu_data_o, 0);
    check("arst_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h600, 4'hF, 32'h0, 32'h1357_9BDF, 0, 6'd0, 0);

`ifdef DBUS_TIMEOUT_EN
    // Slave never acks: error in the 8th BUSY cycle.
    next_cycle();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h700; cpu_sel = 4'hF; stall = 6'b001111;
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      @(negedge clk);
      check("to_cyc", wb_cyc_o, 1);
      check("to_err", bus_err, (i == 8));
      check("to_stall", stall_req, (i != 8));
      if (i == 8) check("to_data", cpu_data_o, 32'hFFFF_FFFF);
    end
    next_cycle();
    cpu_ce = 1'b0; stall = '0;
    @(negedge clk);
    check("to_drop", wb_cyc_o, 0);
    check("to_err_off", bus_err, 0);
    check("to_state", dut.state_q, DbusIdle);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
